// File: rtl/riscv_pkg.sv
// Shared RISC-V core types and constants used by the fetch stage.
package riscv_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic            valid;
    } if_id_t;

endpackage

// File: rtl/pc_reg.sv
// Program counter with redirect/stall/increment priority and target alignment check.
module pc_reg
    import riscv_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = XLEN,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = DEFAULT_RESET_PC
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall_i,
    input  logic                  redirect_i,
    input  logic [DATA_WIDTH-1:0] target_i,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic [DATA_WIDTH-1:0] pc_plus4_o,
    output logic                  misalign_o
);

    logic [DATA_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0] pc_d;
    logic [DATA_WIDTH-1:0] pc_plus4;

    // Wraps modulo 2^DATA_WIDTH by construction.
    assign pc_plus4 = pc_q + DATA_WIDTH'(4);

    always_comb begin
        pc_d = pc_q;
        if (redirect_i) begin
            pc_d = {target_i[DATA_WIDTH-1:2], 2'b00};
        end else if (!stall_i) begin
            pc_d = pc_plus4;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o       = pc_q;
    assign pc_plus4_o = pc_plus4;
    assign misalign_o = redirect_i && (target_i[1:0] != 2'b00);

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, IF/ID register, one-cycle boot hold,
// sticky misaligned-redirect flag and fetch counter.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = XLEN,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int unsigned           CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall_i,
    input  logic                  redirect_i,
    input  logic [DATA_WIDTH-1:0] redirect_target_i,
    output logic [DATA_WIDTH-1:0] imem_addr_o,
    input  logic [DATA_WIDTH-1:0] imem_rdata_i,
    output logic [DATA_WIDTH-1:0] id_instr_o,
    output logic [DATA_WIDTH-1:0] id_pc_o,
    output logic [DATA_WIDTH-1:0] id_pc_plus4_o,
    output logic                  id_valid_o,
    output logic                  misalign_err_o,
    output logic [CNT_WIDTH-1:0]  fetch_count_o
);

    fetch_state_e state_q, state_d;
    logic         boot;

    logic                  stall_eff;
    logic                  redirect_eff;
    logic                  capture;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] pc_plus4;
    logic                  misalign_pulse;

    if_id_t                if_id_q, if_id_d;
    logic                  misalign_q, misalign_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = BOOT;
        endcase
    end

    always_comb begin
        boot = (state_q == BOOT);
    end

    // During BOOT the pipeline is frozen: stall forced, redirect masked.
    assign stall_eff    = stall_i | boot;
    assign redirect_eff = redirect_i & ~boot;
    assign capture      = !redirect_eff && !stall_eff;

    pc_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .RESET_PC   (RESET_PC)
    ) u_pc_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall_i    (stall_eff),
        .redirect_i (redirect_eff),
        .target_i   (redirect_target_i),
        .pc_o       (pc),
        .pc_plus4_o (pc_plus4),
        .misalign_o (misalign_pulse)
    );

    always_comb begin
        if_id_d    = if_id_q;
        misalign_d = misalign_q | misalign_pulse;
        cnt_d      = cnt_q;
        if (redirect_eff) begin
            if_id_d.instr    = NOP_INSTR;
            if_id_d.pc       = '0;
            if_id_d.pc_plus4 = '0;
            if_id_d.valid    = 1'b0;
        end else if (capture) begin
            if_id_d.instr    = imem_rdata_i;
            if_id_d.pc       = pc;
            if_id_d.pc_plus4 = pc_plus4;
            if_id_d.valid    = 1'b1;
            cnt_d            = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            if_id_q.instr    <= NOP_INSTR;
            if_id_q.pc       <= '0;
            if_id_q.pc_plus4 <= '0;
            if_id_q.valid    <= 1'b0;
            misalign_q       <= 1'b0;
            cnt_q            <= '0;
        end else begin
            if_id_q    <= if_id_d;
            misalign_q <= misalign_d;
            cnt_q      <= cnt_d;
        end
    end

    assign imem_addr_o    = pc;
    assign id_instr_o     = if_id_q.instr;
    assign id_pc_o        = if_id_q.pc;
    assign id_pc_plus4_o  = if_id_q.pc_plus4;
    assign id_valid_o     = if_id_q.valid;
    assign misalign_err_o = misalign_q;
    assign fetch_count_o  = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a small combinational instruction memory model.
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_target_i;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_rdata_i;
    logic [31:0] id_instr_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_pc_plus4_o;
    logic        id_valid_o;
    logic        misalign_err_o;
    logic [31:0] fetch_count_o;

    int total = 0;
    int bad   = 0;

    fetch_stage dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .stall_i           (stall_i),
        .redirect_i        (redirect_i),
        .redirect_target_i (redirect_target_i),
        .imem_addr_o       (imem_addr_o),
        .imem_rdata_i      (imem_rdata_i),
        .id_instr_o        (id_instr_o),
        .id_pc_o           (id_pc_o),
        .id_pc_plus4_o     (id_pc_plus4_o),
        .id_valid_o        (id_valid_o),
        .misalign_err_o    (misalign_err_o),
        .fetch_count_o     (fetch_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word at address 0 is the boot instruction; every other word is addr ^ 0x1357_0000.
    always_comb begin
        imem_rdata_i = (imem_addr_o == 32'h0) ? 32'h0050_0093 : (imem_addr_o ^ 32'h1357_0000);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_target_i = 32'h0;
        step(); step(); step();
        total++; if (imem_addr_o !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=%h", imem_addr_o, 32'h0); end
        total++; if (id_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", id_valid_o); end
        total++; if (id_instr_o !== 32'h13) begin bad++; $display("FAIL reset_instr got=%h exp=%h", id_instr_o, 32'h13); end
        total++; if (id_pc_o !== 32'h0 || id_pc_plus4_o !== 32'h0) begin bad++; $display("FAIL reset_pcs got=%h/%h exp=0/0", id_pc_o, id_pc_plus4_o); end
        total++; if (misalign_err_o !== 1'b0 || fetch_count_o !== 32'h0) begin bad++; $display("FAIL reset_err_cnt got=%b/%0d exp=0/0", misalign_err_o, fetch_count_o); end
        // The last low-sampled edge above is edge 0; edge 1 is BOOT.
        rst_n = 1'b1;
        step();
        total++; if (id_valid_o !== 1'b0 || imem_addr_o !== 32'h0) begin bad++; $display("FAIL boot_hold got=%b/%h exp=0/0", id_valid_o, imem_addr_o); end
        step();
        total++; if (id_valid_o !== 1'b1) begin bad++; $display("FAIL first_valid got=%b exp=1", id_valid_o); end
        total++; if (id_instr_o !== 32'h0050_0093) begin bad++; $display("FAIL first_instr got=%h exp=%h", id_instr_o, 32'h0050_0093); end
        total++; if (id_pc_o !== 32'h0 || id_pc_plus4_o !== 32'h4) begin bad++; $display("FAIL first_pcs got=%h/%h exp=0/4", id_pc_o, id_pc_plus4_o); end
    endtask

    task automatic test_sequential();
        for (int i = 1; i <= 3; i++) begin
            step();
            total++; if (id_pc_o !== 32'(4 * i)) begin bad++; $display("FAIL seq_pc%0d got=%h exp=%h", i, id_pc_o, 32'(4 * i)); end
            total++; if (id_instr_o !== (32'(4 * i) ^ 32'h1357_0000)) begin bad++; $display("FAIL seq_instr%0d got=%h exp=%h", i, id_instr_o, 32'(4 * i) ^ 32'h1357_0000); end
        end
        total++; if (fetch_count_o !== 32'd4) begin bad++; $display("FAIL seq_count got=%0d exp=4", fetch_count_o); end
        total++; if (imem_addr_o !== 32'h10) begin bad++; $display("FAIL seq_addr got=%h exp=%h", imem_addr_o, 32'h10); end
    endtask

    task automatic test_stall();
        // Re-steer to 0 so IF/ID reaches PC 8 with a known count (4 + 3 = 7).
        redirect_i = 1'b1; redirect_target_i = 32'h0;
        step();
        redirect_i = 1'b0;
        step(); step(); step();
        total++; if (id_pc_o !== 32'h8 || imem_addr_o !== 32'hC) begin bad++; $display("FAIL stall_setup got=%h/%h exp=8/c", id_pc_o, imem_addr_o); end
        total++; if (fetch_count_o !== 32'd7) begin bad++; $display("FAIL stall_setup_cnt got=%0d exp=7", fetch_count_o); end
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (imem_addr_o !== 32'hC || id_pc_o !== 32'h8) begin bad++; $display("FAIL stall_hold%0d got=%h/%h exp=c/8", i, imem_addr_o, id_pc_o); end
            total++; if (fetch_count_o !== 32'd7 || id_valid_o !== 1'b1) begin bad++; $display("FAIL stall_cnt%0d got=%0d/%b exp=7/1", i, fetch_count_o, id_valid_o); end
        end
    endtask

    task automatic test_redirect();
        redirect_i = 1'b1; redirect_target_i = 32'h40;
        step();
        total++; if (id_valid_o !== 1'b0 || id_instr_o !== 32'h13) begin bad++; $display("FAIL redir_bubble got=%b/%h exp=0/13", id_valid_o, id_instr_o); end
        total++; if (imem_addr_o !== 32'h40) begin bad++; $display("FAIL redir_addr got=%h exp=%h", imem_addr_o, 32'h40); end
        total++; if (id_pc_o !== 32'h0 || fetch_count_o !== 32'd7) begin bad++; $display("FAIL redir_flush got=%h/%0d exp=0/7", id_pc_o, fetch_count_o); end
        redirect_i = 1'b0; stall_i = 1'b0;
        step();
        total++; if (id_pc_o !== 32'h40 || id_valid_o !== 1'b1) begin bad++; $display("FAIL redir_target got=%h/%b exp=40/1", id_pc_o, id_valid_o); end
        total++; if (id_instr_o !== 32'h1357_0040 || id_pc_plus4_o !== 32'h44) begin bad++; $display("FAIL redir_entry got=%h/%h exp=13570040/44", id_instr_o, id_pc_plus4_o); end
        total++; if (fetch_count_o !== 32'd8) begin bad++; $display("FAIL redir_count got=%0d exp=8", fetch_count_o); end
    endtask

    task automatic test_misalign();
        redirect_i = 1'b1; redirect_target_i = 32'h42;
        step();
        total++; if (imem_addr_o !== 32'h40 || misalign_err_o !== 1'b1) begin bad++; $display("FAIL mis_set got=%h/%b exp=40/1", imem_addr_o, misalign_err_o); end
        redirect_target_i = 32'h80;
        step();
        total++; if (imem_addr_o !== 32'h80 || misalign_err_o !== 1'b1) begin bad++; $display("FAIL mis_sticky got=%h/%b exp=80/1", imem_addr_o, misalign_err_o); end
        redirect_i = 1'b0;
        step();
        total++; if (id_pc_o !== 32'h80 || misalign_err_o !== 1'b1) begin bad++; $display("FAIL mis_hold got=%h/%b exp=80/1", id_pc_o, misalign_err_o); end
        // Reset wins over concurrent stall and redirect.
        rst_n = 1'b0; stall_i = 1'b1; redirect_i = 1'b1; redirect_target_i = 32'h100;
        step();
        total++; if (misalign_err_o !== 1'b0 || imem_addr_o !== 32'h0) begin bad++; $display("FAIL mis_reset got=%b/%h exp=0/0", misalign_err_o, imem_addr_o); end
        total++; if (id_valid_o !== 1'b0 || fetch_count_o !== 32'd0) begin bad++; $display("FAIL mid_reset got=%b/%0d exp=0/0", id_valid_o, fetch_count_o); end
        // BOOT ignores redirect, including a misaligned one.
        rst_n = 1'b1; stall_i = 1'b0; redirect_target_i = 32'h202;
        step();
        total++; if (imem_addr_o !== 32'h0 || misalign_err_o !== 1'b0 || id_valid_o !== 1'b0) begin bad++; $display("FAIL boot_ignore got=%h/%b/%b exp=0/0/0", imem_addr_o, misalign_err_o, id_valid_o); end
        redirect_i = 1'b0;
        step();
        total++; if (id_valid_o !== 1'b1 || id_pc_o !== 32'h0 || id_instr_o !== 32'h0050_0093) begin bad++; $display("FAIL reboot got=%b/%h/%h exp=1/0/00500093", id_valid_o, id_pc_o, id_instr_o); end
    endtask

    task automatic test_wrap();
        redirect_i = 1'b1; redirect_target_i = 32'hFFFF_FFFC;
        step();
        total++; if (imem_addr_o !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_addr0 got=%h exp=%h", imem_addr_o, 32'hFFFF_FFFC); end
        redirect_i = 1'b0;
        step();
        total++; if (imem_addr_o !== 32'h0) begin bad++; $display("FAIL wrap_addr1 got=%h exp=0", imem_addr_o); end
        total++; if (id_pc_o !== 32'hFFFF_FFFC || id_pc_plus4_o !== 32'h0) begin bad++; $display("FAIL wrap_entry got=%h/%h exp=fffffffc/0", id_pc_o, id_pc_plus4_o); end
        total++; if (id_instr_o !== 32'hECA8_FFFC) begin bad++; $display("FAIL wrap_instr got=%h exp=%h", id_instr_o, 32'hECA8_FFFC); end
        step();
        total++; if (id_pc_o !== 32'h0 || id_instr_o !== 32'h0050_0093 || imem_addr_o !== 32'h4) begin bad++; $display("FAIL wrap_next got=%h/%h/%h exp=0/00500093/4", id_pc_o, id_instr_o, imem_addr_o); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_misalign();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
